// File: rtl/i2s_pkg.sv
// Shared I2S definitions: sample type, frame geometry and the
// slot-to-sample bit mapping used by the transmitter and receiver.
package i2s_pkg;

    localparam int SAMPLE_W        = 16;
    localparam int SLOT_W          = 32;
    localparam int SLOTS_PER_FRAME = 2 * SLOT_W;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef struct packed {
        logic       channel;
        logic [7:0] k;
        logic       pad;
    } slot_bit_t;

    // Standard I2S: the bit at slot s belongs to position s-1 (one BCLK delay)
    function automatic slot_bit_t slot_bit_index(
        input int s,
        input int slot_w,
        input int sample_w
    );
        int        p;
        int        k;
        slot_bit_t r;
        p = (s == 0) ? 2 * slot_w - 1 : s - 1;
        r.channel = (p >= slot_w);
        k = r.channel ? p - slot_w : p;
        r.k = 8'(k);
        r.pad = (k >= sample_w);
        return r;
    endfunction

endpackage

// File: rtl/i2s_transmitter_if.sv
// Sample handshake between a sample producer and the I2S transmitter.
// One stereo pair moves on each cycle with valid and ready both high.
interface i2s_transmitter_if
    import i2s_pkg::*;
#(
    parameter int SAMPLE_WIDTH = SAMPLE_W
);

    logic [SAMPLE_WIDTH-1:0] left_sample_in;
    logic [SAMPLE_WIDTH-1:0] right_sample_in;
    logic                    sample_valid_in;
    logic                    sample_ready_out;

    modport master (
        output left_sample_in,
        output right_sample_in,
        output sample_valid_in,
        input  sample_ready_out
    );

    modport slave (
        input  left_sample_in,
        input  right_sample_in,
        input  sample_valid_in,
        output sample_ready_out
    );

endinterface

// File: rtl/i2s_clk_gen.sv
// BCLK divider and slot counter; fall_en marks the cycle whose edge
// takes bclk low, which is when every serial output advances.
module i2s_clk_gen #(
    parameter int  BCLK_HALF = 12,
    parameter int  SLOTS     = 64,
    localparam int DW        = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1,
    localparam int CW        = $clog2(SLOTS)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    output logic          bclk,
    output logic          fall_en,
    output logic [CW-1:0] s
);

    logic [DW-1:0] div;
    logic          wrap;

    assign wrap    = (div == DW'(BCLK_HALF - 1));
    assign fall_en = wrap & bclk;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            div  <= '0;
            bclk <= 1'b0;
            s    <= CW'(SLOTS - 1);
        end else begin
            div <= wrap ? '0 : div + 1'b1;
            if (wrap) bclk <= ~bclk;
            if (fall_en) s <= (s == CW'(SLOTS - 1)) ? '0 : s + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_transmitter.sv
// I2S master transmitter: one-deep holding register feeding a frame
// register that is serialised MSB first, left slot then right slot.
module i2s_transmitter
    import i2s_pkg::*;
#(
    parameter int SAMPLE_WIDTH = SAMPLE_W,
    parameter int SLOT_WIDTH   = SLOT_W,
    parameter int BCLK_HALF    = 12
) (
    input  logic               clk_in,
    input  logic               rst_in,
    i2s_transmitter_if.slave   smp,
    output logic               i2s_bclk_out,
    output logic               i2s_lrclk_out,
    output logic               i2s_data_out,
    output logic               frame_start_out,
    output logic               underrun_out
);

    localparam int SLOTS = 2 * SLOT_WIDTH;
    localparam int CW    = $clog2(SLOTS);
    localparam int IW    = $clog2(SAMPLE_WIDTH);

    logic                    bclk;
    logic                    fall_en;
    logic [CW-1:0]           s;
    logic [CW-1:0]           s_nxt;
    logic [SAMPLE_WIDTH-1:0] hold_l, hold_r;
    logic [SAMPLE_WIDTH-1:0] frm_l, frm_r;
    logic [SAMPLE_WIDTH-1:0] src;
    logic                    hold_full;
    logic                    ready_q;
    logic                    accept;
    logic                    load;
    logic                    bit_nxt;
    logic [IW-1:0]           idx;
    slot_bit_t               sb;

    i2s_clk_gen #(
        .BCLK_HALF (BCLK_HALF),
        .SLOTS     (SLOTS)
    ) u_clk_gen (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .bclk    (bclk),
        .fall_en (fall_en),
        .s       (s)
    );

    assign s_nxt  = (s == CW'(SLOTS - 1)) ? '0 : s + 1'b1;
    assign load   = fall_en && (s == CW'(SLOTS - 1));
    assign accept = smp.sample_valid_in && ready_q;

    assign smp.sample_ready_out = ready_q;
    assign i2s_bclk_out         = bclk;

    always_comb begin
        sb      = slot_bit_index(int'(s_nxt), SLOT_WIDTH, SAMPLE_WIDTH);
        idx     = IW'(SAMPLE_WIDTH - 1 - int'(sb.k));
        src     = sb.channel ? frm_r : frm_l;
        bit_nxt = !sb.pad && src[idx];
    end

    // ready lags a load by one cycle but drops in the same edge as an accept
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            hold_l          <= '0;
            hold_r          <= '0;
            frm_l           <= '0;
            frm_r           <= '0;
            hold_full       <= 1'b0;
            ready_q         <= 1'b1;
            i2s_lrclk_out   <= 1'b1;
            i2s_data_out    <= 1'b0;
            frame_start_out <= 1'b0;
            underrun_out    <= 1'b0;
        end else begin
            frame_start_out <= load;
            underrun_out    <= load && !hold_full;
            ready_q         <= accept ? 1'b0 : !hold_full;
            if (accept) begin
                hold_l    <= smp.left_sample_in;
                hold_r    <= smp.right_sample_in;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end
            if (load && hold_full) begin
                frm_l <= hold_l;
                frm_r <= hold_r;
            end
            if (fall_en) begin
                i2s_lrclk_out <= (int'(s_nxt) >= SLOT_WIDTH);
                i2s_data_out  <= bit_nxt;
            end
        end
    end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter: BCLK_HALF=12 and BCLK_HALF=2 instances,
// each decoded by an independent I2S deserialiser into frame words.
module tb_i2s_transmitter;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    i2s_transmitter_if #(.SAMPLE_WIDTH(16)) bus0 ();
    i2s_transmitter_if #(.SAMPLE_WIDTH(16)) bus1 ();

    logic bclk0, lr0, dat0, fs0, ur0;
    logic bclk1, lr1, dat1, fs1, ur1;

    i2s_transmitter #(
        .SAMPLE_WIDTH(16), .SLOT_WIDTH(32), .BCLK_HALF(12)
    ) u_dut0 (
        .clk_in          (clk),
        .rst_in          (rst_n),
        .smp             (bus0.slave),
        .i2s_bclk_out    (bclk0),
        .i2s_lrclk_out   (lr0),
        .i2s_data_out    (dat0),
        .frame_start_out (fs0),
        .underrun_out    (ur0)
    );

    i2s_transmitter #(
        .SAMPLE_WIDTH(16), .SLOT_WIDTH(32), .BCLK_HALF(2)
    ) u_dut1 (
        .clk_in          (clk),
        .rst_in          (rst_n),
        .smp             (bus1.slave),
        .i2s_bclk_out    (bclk1),
        .i2s_lrclk_out   (lr1),
        .i2s_data_out    (dat1),
        .frame_start_out (fs1),
        .underrun_out    (ur1)
    );

    int checks = 0;
    int fails = 0;
    int cyc = 0;

    logic [63:0] frames0[$];
    logic [63:0] frames1[$];
    int          fs_cnt0 = 0;
    int          ur_cnt0 = 0;

    // A word ends at the BCLK rise where WS is first seen changed
    logic        pb0, plr0, hl0;
    logic [31:0] sr0, lw0;
    always @(negedge clk) begin
        if (fs0) fs_cnt0 <= fs_cnt0 + 1;
        if (ur0) ur_cnt0 <= ur_cnt0 + 1;
        if (!rst_n) begin
            pb0 <= 1'b0; plr0 <= 1'b1; hl0 <= 1'b0; sr0 <= '0;
        end else begin
            pb0 <= bclk0;
            if (bclk0 && !pb0) begin
                sr0  <= {sr0[30:0], dat0};
                plr0 <= lr0;
                if (lr0 != plr0) begin
                    if (!plr0) begin
                        lw0 <= {sr0[30:0], dat0};
                        hl0 <= 1'b1;
                    end else if (hl0) begin
                        frames0.push_back({lw0, sr0[30:0], dat0});
                        hl0 <= 1'b0;
                    end
                end
            end
        end
    end

    logic        pb1, plr1, hl1;
    logic [31:0] sr1, lw1;
    always @(negedge clk) begin
        if (!rst_n) begin
            pb1 <= 1'b0; plr1 <= 1'b1; hl1 <= 1'b0; sr1 <= '0;
        end else begin
            pb1 <= bclk1;
            if (bclk1 && !pb1) begin
                sr1  <= {sr1[30:0], dat1};
                plr1 <= lr1;
                if (lr1 != plr1) begin
                    if (!plr1) begin
                        lw1 <= {sr1[30:0], dat1};
                        hl1 <= 1'b1;
                    end else if (hl1) begin
                        frames1.push_back({lw1, sr1[30:0], dat1});
                        hl1 <= 1'b0;
                    end
                end
            end
        end
    end

    function automatic logic [63:0] fexp(input logic [31:0] p);
        return {p[31:16], 16'h0000, p[15:0], 16'h0000};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    bit          b2b = 1'b0;
    bit          need_new = 1'b0;
    logic [31:0] cur;
    logic [31:0] acc[$];
    int          acc_cyc[$];

    task automatic drive0(input logic [31:0] p, input logic v);
        bus0.left_sample_in  = p[31:16];
        bus0.right_sample_in = p[15:0];
        bus0.sample_valid_in = v;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (b2b) begin
            if (bus0.sample_ready_out) begin
                acc.push_back(cur);
                acc_cyc.push_back(cyc);
                need_new = 1'b1;
            end else if (need_new) begin
                cur = $urandom;
                drive0(cur, 1'b1);
                need_new = 1'b0;
            end
        end
    endtask

    task automatic wait_frames(input bit which, input int n);
        int k;
        k = 0;
        while ((which ? frames1.size() : frames0.size()) < n && k < 8000) begin
            step();
            k++;
        end
        chk(which ? "wait_frames1" : "wait_frames0",
            64'((which ? frames1.size() : frames0.size()) >= n), 64'd1);
    endtask

    function automatic int next_load(input int c);
        int e;
        e = 24 + 1536 * ((c - 24) / 1536 + 1);
        if (e - c < 3) e += 1536;
        return e;
    endfunction

    localparam logic [31:0] P0 = 32'hA5A5_8001;

    initial begin
        logic [63:0] ded[$];
        logic [31:0] p3, q1, last;
        int          e, n0, n1, k, u_a;

        drive0('0, 1'b0);
        bus1.left_sample_in  = '0;
        bus1.right_sample_in = '0;
        bus1.sample_valid_in = 1'b0;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_outs0", {bclk0, lr0, dat0, bus0.sample_ready_out, fs0, ur0},
            64'b010100);
        chk("rst_outs1", {bclk1, lr1, dat1, bus1.sample_ready_out, fs1, ur1},
            64'b010100);

        rst_n = 1'b1;
        cyc = 0;
        drive0(P0, 1'b1);
        step();
        drive0(P0, 1'b0);
        chk("ready_after_accept", bus0.sample_ready_out, 0);
        while (cyc < 11) step();
        chk("bclk_c11", bclk0, 0);
        step();
        chk("bclk_rise_c12", bclk0, 1);
        while (cyc < 23) step();
        chk("bclk_c23", bclk0, 1);
        step();
        chk("first_fall_c24", {bclk0, lr0, fs0, ur0}, 64'b0010);
        chk("ready_c24", bus0.sample_ready_out, 0);
        step();
        chk("ready_c25", bus0.sample_ready_out, 1);

        wait_frames(1'b0, 3);
        for (int i = 0; i < 3; i++) chk("frame_p0", frames0[i], fexp(P0));
        chk("underrun_cnt", ur_cnt0, 3);
        chk("frame_cnt", fs_cnt0, 4);

        // Back-to-back random pairs with valid held high
        cur = $urandom;
        drive0(cur, 1'b1);
        u_a = ur_cnt0;
        b2b = 1'b1;
        step();
        k = 0;
        while (!fs0 && k < 3000) begin step(); k++; end
        chk("b2b_fs_seen", fs0, 1);
        chk("b2b_ready_at_fs", bus0.sample_ready_out, 0);
        step();
        chk("b2b_ready_after_fs", bus0.sample_ready_out, 1);
        repeat (6 * 1536) step();
        while (bus0.sample_ready_out) step();
        b2b = 1'b0;
        drive0(cur, 1'b0);
        chk("b2b_no_underrun", ur_cnt0, u_a);
        chk("b2b_accepts", 64'(acc.size() >= 6), 1);
        for (int i = 2; i < acc_cyc.size(); i++)
            chk("b2b_gap", acc_cyc[i] - acc_cyc[i-1], 1536);
        repeat (3 * 1536 + 100) step();
        foreach (frames0[i])
            if (ded.size() == 0 || frames0[i] != ded[$]) ded.push_back(frames0[i]);
        chk("b2b_distinct", ded.size(), acc.size() + 1);
        chk("b2b_first", ded[0], fexp(P0));
        for (int i = 0; i < acc.size(); i++)
            chk("b2b_seq", (i + 1 < ded.size()) ? ded[i+1] : 64'hx, fexp(acc[i]));
        last = acc[$];

        // Accept exactly on a load cycle with the holding register empty
        e = next_load(cyc);
        while (cyc < e - 1) step();
        p3 = $urandom;
        drive0(p3, 1'b1);
        n0 = frames0.size();
        step();
        drive0(p3, 1'b0);
        chk("accept_on_load", {fs0, ur0, bus0.sample_ready_out}, 64'b110);
        while (cyc < e + 1535) step();
        chk("ready_held_low", bus0.sample_ready_out, 0);
        step();
        chk("next_load_full", {fs0, ur0, bus0.sample_ready_out}, 64'b100);
        step();
        chk("ready_after_load", bus0.sample_ready_out, 1);
        wait_frames(1'b0, n0 + 3);
        chk("load_cycle_repeat", frames0[n0+1], fexp(last));
        chk("load_cycle_pair", frames0[n0+2], fexp(p3));

        // Reset mid-frame with pending pairs in both instances
        e = next_load(cyc);
        while (cyc < e + 5) step();
        q1 = $urandom;
        drive0($urandom, 1'b1);
        bus1.left_sample_in  = q1[31:16];
        bus1.right_sample_in = q1[15:0];
        bus1.sample_valid_in = 1'b1;
        step();
        drive0('0, 1'b0);
        bus1.sample_valid_in = 1'b0;
        chk("pending0", bus0.sample_ready_out, 0);
        while (cyc < e + 490) step();
        rst_n = 1'b0;
        #1;
        chk("async_rst0", {bclk0, lr0, dat0, bus0.sample_ready_out, fs0, ur0},
            64'b010100);
        chk("async_rst1", {bclk1, lr1, dat1, bus1.sample_ready_out, fs1, ur1},
            64'b010100);
        repeat (4) step();
        rst_n = 1'b1;
        cyc = 0;
        n0 = frames0.size();
        n1 = frames1.size();
        q1 = $urandom;
        bus1.left_sample_in  = q1[31:16];
        bus1.right_sample_in = q1[15:0];
        bus1.sample_valid_in = 1'b1;
        step();
        bus1.sample_valid_in = 1'b0;
        chk("h2_ready_c1", bus1.sample_ready_out, 0);
        step();
        chk("h2_rise_c2", bclk1, 1);
        step();
        chk("h2_c3", bclk1, 1);
        step();
        chk("h2_fall_c4", {bclk1, lr1, fs1, ur1}, 64'b0010);
        while (cyc < 24) step();
        chk("dropped_underrun", {fs0, ur0}, 64'b11);
        wait_frames(1'b1, n1 + 2);
        chk("h2_frame0", frames1[n1], fexp(q1));
        chk("h2_frame1", frames1[n1+1], fexp(q1));
        wait_frames(1'b0, n0 + 1);
        chk("dropped_pair", frames0[n0], 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/i2s_transmitter.md
Name: i2s_transmitter

Overview:
- I2S master transmitter: the output-side counterpart of i2s_receiver.
- Serialises signed 16-bit left/right samples (e.g. the anti-noise output of fir63) to an external I2S DAC/amp.
- Generates its own BCLK and LRCLK from the 100 MHz system clock.
- Accepts one stereo sample per frame through a valid/ready handshake with a one-deep holding register.

Parameters:
- SAMPLE_WIDTH, 16: bits per channel sample, two's complement, MSB first.
- SLOT_WIDTH, 32: BCLK periods per channel slot; must be >= SAMPLE_WIDTH. Frame = 2*SLOT_WIDTH = 64 BCLKs.
- BCLK_HALF, 12: system clocks per BCLK half-period; must be >= 2. 100 MHz/24 = 4.167 MHz BCLK.

Ports:
- clk_in  input  1  system clock, 100 MHz
- rst_in  input  1  asynchronous, active-low reset
- left_sample_in  input  SAMPLE_WIDTH  left sample, signed
- right_sample_in  input  SAMPLE_WIDTH  right sample, signed
- sample_valid_in  input  1  sample pair present
- sample_ready_out  output  1  holding register empty; transfer when valid&&ready
- i2s_bclk_out  output  1  bit clock
- i2s_lrclk_out  output  1  word select: 0 = left, 1 = right
- i2s_data_out  output  1  serial data; changes on BCLK falling edge
- frame_start_out  output  1  1-cycle pulse when a frame register is loaded
- underrun_out  output  1  1-cycle pulse when a frame starts with the holding register empty

Behaviour:
- Reset, asynchronous on rst_in==0:
  - div=0, bclk=0, slot counter s=SLOTS-1 (63), lrclk=1, data=0.
  - Holding register empty, so ready=1; frame register = 0; pulses = 0.
- Divider:
  - div counts 0..BCLK_HALF-1; at BCLK_HALF-1 it wraps to 0 and bclk toggles.
  - First BCLK rise is registered at cycle BCLK_HALF after reset release; first fall at 2*BCLK_HALF.
- Falling-edge cycle (the cycle bclk is registered 1->0):
  - s <= (s==63) ? 0 : s+1.
  - lrclk <= (s_next >= SLOT_WIDTH).
  - data <= bit(s_next); all three outputs update in the same cycle.
- Bit mapping, standard I2S with one-BCLK delay:
  - p = (s-1) mod 64; channel = left if p < SLOT_WIDTH, else right; k = p mod SLOT_WIDTH.
  - data = sample[SAMPLE_WIDTH-1-k] when k < SAMPLE_WIDTH, else 0.
  - At s=0 the bit is right-slot padding (0). Left MSB is driven at s=1.
- Frame load happens in the falling-edge cycle where s wraps 63->0. The first load occurs at the first BCLK fall after reset.
  - Holding full: frame register <= holding register; holding is cleared; frame_start_out pulses.
  - Holding empty: frame register unchanged (the last pair repeats; all zeros after reset); frame_start_out and underrun_out both pulse.
- Handshake:
  - sample_ready_out = !holding_full, driven from a registered flag.
  - Accepts only when valid&&ready; a pair is never overwritten.
  - Accept and load in the same cycle: holding was empty at the load, so this counts as underrun. The new pair is stored and goes to the next frame.
  - Holding full at load: ready rises the cycle after the load. Throughput is at most 1 pair per 64*2*BCLK_HALF = 1536 cycles.
- Inputs are sampled only on the accept cycle; they may change freely otherwise.
- Reset mid-frame: all state returns to reset values immediately, including any pending holding data (discarded). There is no partial-frame recovery.
- Outputs are glitch-free: every output is driven directly from a flop.

Decomposition:
- i2s_pkg:
  - sample_t (logic signed [15:0]);
  - SLOTS_PER_FRAME = 64;
  - function slot_bit_index(s) returning {channel, k, pad}.
  - Shared with i2s_receiver.
- Sub-module i2s_clk_gen:
  - contains the divider, bclk flop and slot counter;
  - outputs bclk, fall_en (1-cycle strobe) and s.
- The transmitter top holds the handshake, holding/frame registers and the output mux.

Test Plan:
- Reset: hold rst_in=0 for 5 cycles -> bclk=0, lrclk=1, data=0, ready=1, no pulses. Release -> bclk rises at cycle 12, falls at 24; lrclk=0 and frame_start_out pulses in that same cycle.
- Single pair: push L=16'hA5A5, R=16'h8001 before the first frame. A bench deserialiser sampling on BCLK rise reads left slot A5A5_0000 and right slot 8001_0000. LRCLK toggles one BCLK before each MSB.
- Underrun: push one pair, then stop -> the next frame repeats A5A5/8001 exactly and underrun_out pulses once per frame.
- Back-to-back: hold valid=1 with an incrementing L/R counter -> ready drops after each accept and rises 1 cycle after frame_start_out. Exactly 1 accept per 1536 cycles, with no skipped or duplicated values.
- Accept on the load cycle: raise valid exactly on the wrap cycle with holding empty -> underrun pulse; the pair appears in the following frame; ready=0 until that load.
- Mid-frame reset at s=20: pull rst_in low -> outputs return to reset values within the same cycle (asynchronous) and the pending pair is dropped. Repeat with BCLK_HALF=2: BCLK period is 4 cycles and the bit mapping is identical.
